// File: rtl/nvdla_noc_axi_pkg.sv
`default_nettype none
// ============================================================================
// nvdla_noc_axi_pkg -- AXI write-path widths, BRESP encodings, queue entries
// Rev 1.0
// ============================================================================
package nvdla_noc_axi_pkg;

  localparam int AXI_ID_W   = 8;
  localparam int AXI_LEN_W  = 4;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_DATA_W = 512;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int BEAT_BYTES = 64;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_LEN_W-1:0]  len;
    logic [AXI_ADDR_W-1:0] addr;
  } aw_entry_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_entry_t;

endpackage
`default_nettype wire

// File: rtl/nvdla_noc_sync_fifo.sv
`default_nettype none
// ============================================================================
// nvdla_noc_sync_fifo -- single-clock FIFO, registered full/empty flags
// Rev 1.0
// ============================================================================
module nvdla_noc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
  always_comb begin
    pop_ok   = pop & ~empty_q;
    push_ok  = push & (~full_q | pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
    full_d   = (cnt_d == CW'(DEPTH));
    empty_d  = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule
`default_nettype wire

// File: rtl/nvdla_noc_axi_wr_rsp.sv
`default_nettype none
// ============================================================================
// nvdla_noc_axi_wr_rsp -- AXI write slave: AW/W to memory writes, ordered B.
// NVDLA_AXI_WR_RSP_CHK_EN enables wlast checking (SLVERR + error counter).
// Rev 1.0
// ============================================================================
module nvdla_noc_axi_wr_rsp
  import nvdla_noc_axi_pkg::*;
#(
  parameter int AW_DEPTH = 4,
  parameter int B_DEPTH  = 4
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  noc2mem_axi_aw_awvalid,
  output logic                  noc2mem_axi_aw_awready,
  input  logic [AXI_ID_W-1:0]   noc2mem_axi_aw_awid,
  input  logic [AXI_LEN_W-1:0]  noc2mem_axi_aw_awlen,
  input  logic [AXI_ADDR_W-1:0] noc2mem_axi_aw_awaddr,
  input  logic                  noc2mem_axi_w_wvalid,
  output logic                  noc2mem_axi_w_wready,
  input  logic [AXI_DATA_W-1:0] noc2mem_axi_w_wdata,
  input  logic [AXI_STRB_W-1:0] noc2mem_axi_w_wstrb,
  input  logic                  noc2mem_axi_w_wlast,
  output logic                  mem2noc_axi_b_bvalid,
  input  logic                  mem2noc_axi_b_bready,
  output logic [AXI_ID_W-1:0]   mem2noc_axi_b_bid,
  output logic [1:0]            mem2noc_axi_b_bresp,
  output logic                  mem_wr_en,
  output logic [AXI_ADDR_W-1:0] mem_wr_addr,
  output logic [AXI_DATA_W-1:0] mem_wr_data,
  output logic [AXI_STRB_W-1:0] mem_wr_strb,
  output logic [7:0]            mem_wr_err_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [AXI_LEN_W-1:0]  beat_q, beat_d;
  aw_entry_t             burst_q, burst_d;
  logic                  rdy_q;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [AXI_ADDR_W-1:0] mem_wr_addr_q, mem_wr_addr_d;
  logic [AXI_DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic [AXI_STRB_W-1:0] mem_wr_strb_q, mem_wr_strb_d;

  aw_entry_t             aw_push_entry, aw_head;
  b_entry_t              b_push_entry, b_head;
  logic                  aw_push, aw_pop, aw_full, aw_empty;
  logic                  b_push, b_pop, b_full, b_empty;
  logic                  w_hs, last_beat, burst_bad;
  logic [AXI_ADDR_W-1:0] beat_addr;
  logic [BEAT_SHIFT-1:0] beat_addr_lsb_unused;

  // awready is held low in reset and rises on the first edge after release.
  assign noc2mem_axi_aw_awready = rdy_q & ~aw_full;
  assign aw_push                = noc2mem_axi_aw_awvalid & noc2mem_axi_aw_awready;
  assign aw_push_entry          = {noc2mem_axi_aw_awid, noc2mem_axi_aw_awlen, noc2mem_axi_aw_awaddr};

  assign noc2mem_axi_w_wready = (state_q == ST_DATA);
  assign w_hs                 = noc2mem_axi_w_wvalid & noc2mem_axi_w_wready;
  assign last_beat            = (beat_q == burst_q.len);
  assign beat_addr            = burst_q.addr +
                                {{(AXI_ADDR_W-AXI_LEN_W-BEAT_SHIFT){1'b0}}, beat_q, {BEAT_SHIFT{1'b0}}};
  assign beat_addr_lsb_unused = beat_addr[BEAT_SHIFT-1:0];

  assign mem2noc_axi_b_bvalid = ~b_empty;
  assign b_pop                = mem2noc_axi_b_bvalid & mem2noc_axi_b_bready;
  assign mem2noc_axi_b_bid    = b_head.id   & {AXI_ID_W{~b_empty}};
  assign mem2noc_axi_b_bresp  = b_head.resp & {2{~b_empty}};

  nvdla_noc_sync_fifo #(
    .WIDTH ($bits(aw_entry_t)),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (aw_push),
    .push_data (aw_push_entry),
    .pop       (aw_pop),
    .pop_data  (aw_head),
    .full      (aw_full),
    .empty     (aw_empty)
  );

  nvdla_noc_sync_fifo #(
    .WIDTH ($bits(b_entry_t)),
    .DEPTH (B_DEPTH)
  ) u_b_fifo (
    .clk       (nvdla_core_clk),
    .rst_n     (nvdla_core_rstn),
    .push      (b_push),
    .push_data (b_push_entry),
    .pop       (b_pop),
    .pop_data  (b_head),
    .full      (b_full),
    .empty     (b_empty)
  );

  // A burst only starts with a free B slot, so its response can never be dropped.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    burst_d       = burst_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_wr_strb_d = mem_wr_strb_q;
    aw_pop        = 1'b0;
    b_push        = 1'b0;
    b_push_entry  = {burst_q.id, (burst_bad ? BRESP_SLVERR : BRESP_OKAY)};
    case (state_q)
      ST_IDLE: begin
        if (!aw_empty && !b_full) begin
          aw_pop  = 1'b1;
          burst_d = aw_head;
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          mem_wr_en_d   = 1'b1;
          mem_wr_addr_d = {beat_addr[AXI_ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
          mem_wr_data_d = noc2mem_axi_w_wdata;
          mem_wr_strb_d = noc2mem_axi_w_wstrb;
          beat_d        = beat_q + AXI_LEN_W'(1);
          if (last_beat) begin
            b_push  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      burst_q       <= '0;
      rdy_q         <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_wr_strb_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      burst_q       <= burst_d;
      rdy_q         <= 1'b1;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_wr_strb_q <= mem_wr_strb_d;
    end
  end

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_strb = mem_wr_strb_q;

`ifdef NVDLA_AXI_WR_RSP_CHK_EN
  logic       bad_q, bad_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // A beat is malformed when wlast disagrees with awlen; length still follows awlen.
  assign burst_bad = bad_q | (noc2mem_axi_w_wlast != last_beat);

  always_comb begin
    bad_d     = bad_q;
    err_cnt_d = err_cnt_q;
    if (aw_pop) begin
      bad_d = 1'b0;
    end else if (w_hs) begin
      bad_d = burst_bad;
    end
    if (b_push && burst_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      bad_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      bad_q     <= bad_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign mem_wr_err_cnt = err_cnt_q;
`else
  logic wlast_unused;

  assign wlast_unused   = noc2mem_axi_w_wlast;
  assign burst_bad      = 1'b0;
  assign mem_wr_err_cnt = '0;
`endif

endmodule
`default_nettype wire
